// File: rtl/jpeg_code_mux_pkg.sv
// rtl/jpeg_code_mux_pkg.sv - shared entropy-coder types, MODE encodings and clog2 helper
package jpeg_code_mux_pkg;

   localparam int MODE_444 = 0;
   localparam int MODE_420 = 1;

   localparam int CODE_WIDTH_DEFAULT = 32;

   typedef struct packed {
      logic                          eob;
      logic [CODE_WIDTH_DEFAULT-1:0] data;
   } code_word_t;

   // ceil(log2(n)), never below 1 so single-entry selects still get a real bit
   function automatic int clog2_min1(input int n);
      int r;
      r = 0;
      while ((1 << r) < n) r++;
      return (r < 1) ? 1 : r;
   endfunction

endpackage

// File: rtl/code_fifo.sv
// rtl/code_fifo.sv - single-channel synchronous FIFO with occupancy count, full and empty
module code_fifo
   import jpeg_code_mux_pkg::*;
#(
   parameter int WIDTH = 33,
   parameter int DEPTH = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty
);

   localparam int AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW:0]      count;
   logic             do_push;
   logic             do_pop;

   // full comes from the registered count, so a full FIFO refuses a push even when popped
   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;
   assign rdata   = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= wdata;
   end

endmodule

// File: rtl/jpeg_code_mux.sv
// rtl/jpeg_code_mux.sv - merges per-channel entropy-coder streams into one stream in MCU order
module jpeg_code_mux
   import jpeg_code_mux_pkg::*;
#(
   parameter int CODE_WIDTH = 32,
   parameter int CHANNELS   = 3,
   parameter int FIFO_DEPTH = 16,
   parameter int MODE       = MODE_444
) (
   input  logic                                 clk,
   input  logic                                 rst,
   input  logic [CHANNELS-1:0]                  in_valid,
   input  logic [CHANNELS-1:0][CODE_WIDTH-1:0]  in_data,
   input  logic [CHANNELS-1:0]                  in_eob,
   output logic [CHANNELS-1:0]                  in_ready,
   output logic                                 out_valid,
   output logic [CODE_WIDTH-1:0]                out_data,
   output logic                                 out_eob,
   output logic [clog2_min1(CHANNELS)-1:0]      out_chan,
   input  logic                                 out_ready,
   output logic                                 mcu_done,
   output logic [CHANNELS-1:0]                  overflow
);

   localparam int CHW = clog2_min1(CHANNELS);
   localparam int WW  = CODE_WIDTH + 1;

   logic [CHANNELS-1:0] fifo_full;
   logic [CHANNELS-1:0] fifo_empty;
   logic [CHANNELS-1:0] fifo_pop;
   logic [WW-1:0]       fifo_rdata [CHANNELS];

   logic [CHW-1:0]      cur_chan;
   logic [1:0]          blk_cnt;
   logic [WW-1:0]       head;
   logic                head_valid;
   logic                pop_eob;
   logic                last_chan;

   genvar g;
   generate
      for (g = 0; g < CHANNELS; g++) begin : g_chan
         code_fifo #(
            .WIDTH (WW),
            .DEPTH (FIFO_DEPTH)
         ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (in_valid[g]),
            .wdata ({in_eob[g], in_data[g]}),
            .pop   (fifo_pop[g]),
            .rdata (fifo_rdata[g]),
            .full  (fifo_full[g]),
            .empty (fifo_empty[g])
         );
      end
   endgenerate

   assign in_ready = ~fifo_full;

   always_comb begin
      head       = '0;
      head_valid = 1'b0;
      fifo_pop   = '0;
      for (int i = 0; i < CHANNELS; i++) begin
         if (cur_chan == CHW'(i)) begin
            head        = fifo_rdata[i];
            head_valid  = ~fifo_empty[i];
            fifo_pop[i] = out_ready;
         end
      end
   end

   assign out_valid = head_valid;
   assign out_data  = head[CODE_WIDTH-1:0];
   assign out_eob   = head[CODE_WIDTH];
   assign out_chan  = cur_chan;
   assign pop_eob   = head_valid & out_ready & head[CODE_WIDTH];
   assign last_chan = (cur_chan == CHW'(CHANNELS-1));

   // In 4:2:0 the luma channel owns four consecutive blocks before chroma gets a turn
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cur_chan <= '0;
         blk_cnt  <= '0;
         mcu_done <= 1'b0;
         overflow <= '0;
      end else begin
         mcu_done <= 1'b0;
         overflow <= overflow | (in_valid & fifo_full);
         if (pop_eob) begin
            if (MODE == MODE_420 && cur_chan == '0 && blk_cnt != 2'd3) begin
               blk_cnt <= blk_cnt + 1'b1;
            end else begin
               blk_cnt <= '0;
               if (last_chan) begin
                  cur_chan <= '0;
                  mcu_done <= 1'b1;
               end else begin
                  cur_chan <= cur_chan + 1'b1;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_jpeg_code_mux.sv
// tb/tb_jpeg_code_mux.sv - bench for jpeg_code_mux: 4:4:4 and 4:2:0 instances against an MCU-schedule model
module tb_jpeg_code_mux;

   localparam int CW = 16;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic [2:0]         iv [2];
   logic [2:0]         ie [2];
   logic [2:0][CW-1:0] id [2];
   logic [2:0]         ir [2];
   logic [2:0]         of [2];
   logic               ordy [2];
   logic               ov [2];
   logic               oe [2];
   logic               md [2];
   logic [CW-1:0]      od [2];
   logic [1:0]         oc [2];

   jpeg_code_mux #(.CODE_WIDTH(CW), .CHANNELS(3), .FIFO_DEPTH(4), .MODE(0)) dut0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_data(id[0]), .in_eob(ie[0]),
      .in_ready(ir[0]), .out_valid(ov[0]), .out_data(od[0]), .out_eob(oe[0]),
      .out_chan(oc[0]), .out_ready(ordy[0]), .mcu_done(md[0]), .overflow(of[0]));

   jpeg_code_mux #(.CODE_WIDTH(CW), .CHANNELS(3), .FIFO_DEPTH(8), .MODE(1)) dut1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_data(id[1]), .in_eob(ie[1]),
      .in_ready(ir[1]), .out_valid(ov[1]), .out_data(od[1]), .out_eob(oe[1]),
      .out_chan(oc[1]), .out_ready(ordy[1]), .mcu_done(md[1]), .overflow(of[1]));

   // Model: per-channel word queues plus the channel order of one MCU, walked one block at a time
   logic [CW:0] mq [6][$];
   int          sched [2][6];
   int          slen [2];
   int          dep [2];
   int          pos [2];
   logic [2:0]  movf [2];
   logic        mexp [2];
   int          pop_log [2][$];
   int          mcu_seen [2];
   int          n_cmp;
   int          n_fail;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      for (int i = 0; i < 6; i++) mq[i].delete();
      for (int k = 0; k < 2; k++) begin
         pos[k]  = 0;
         movf[k] = '0;
         mexp[k] = 1'b0;
      end
   endtask

   task automatic model_step(input int k);
      int          ch;
      bit          rdy [3];
      logic [CW:0] w;
      ch = sched[k][pos[k]];
      for (int c = 0; c < 3; c++) rdy[c] = mq[k*3+c].size() < dep[k];
      mexp[k] = 1'b0;
      if (ordy[k] && mq[k*3+ch].size() > 0) begin
         w = mq[k*3+ch].pop_front();
         pop_log[k].push_back(ch);
         if (w[CW]) begin
            pos[k]++;
            if (pos[k] == slen[k]) begin
               pos[k]  = 0;
               mexp[k] = 1'b1;
            end
         end
      end
      for (int c = 0; c < 3; c++) begin
         if (iv[k][c]) begin
            if (rdy[c]) mq[k*3+c].push_back({ie[k][c], id[k][c]});
            else        movf[k][c] = 1'b1;
         end
      end
   endtask

   task automatic compare(input int k);
      int          ch;
      bit          v;
      logic [CW:0] h;
      logic [2:0]  er;
      ch = sched[k][pos[k]];
      v  = mq[k*3+ch].size() > 0;
      chk($sformatf("d%0d_out_valid", k), 32'(ov[k]), 32'(v));
      if (v) begin
         h = mq[k*3+ch][0];
         chk($sformatf("d%0d_out_data", k), 32'(od[k]), 32'(h[CW-1:0]));
         chk($sformatf("d%0d_out_eob", k), 32'(oe[k]), 32'(h[CW]));
         chk($sformatf("d%0d_out_chan", k), 32'(oc[k]), 32'(ch));
      end
      for (int c = 0; c < 3; c++) er[c] = mq[k*3+c].size() < dep[k];
      chk($sformatf("d%0d_in_ready", k), 32'(ir[k]), 32'(er));
      chk($sformatf("d%0d_overflow", k), 32'(of[k]), 32'(movf[k]));
      chk($sformatf("d%0d_mcu_done", k), 32'(md[k]), 32'(mexp[k]));
      if (md[k]) mcu_seen[k]++;
   endtask

   task automatic tick();
      model_step(0);
      model_step(1);
      @(posedge clk);
      @(negedge clk);
      compare(0);
      compare(1);
   endtask

   task automatic clear_in();
      for (int k = 0; k < 2; k++) begin
         iv[k] = '0;
         ie[k] = '0;
         id[k] = '0;
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      clear_in();
      #1;
      model_clear();
      for (int k = 0; k < 2; k++) begin
         chk($sformatf("rst_d%0d_out_valid", k), 32'(ov[k]), 32'd0);
         chk($sformatf("rst_d%0d_in_ready", k), 32'(ir[k]), 32'h7);
         chk($sformatf("rst_d%0d_overflow", k), 32'(of[k]), 32'd0);
         chk($sformatf("rst_d%0d_mcu_done", k), 32'(md[k]), 32'd0);
      end
      @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      compare(0);
      compare(1);
   endtask

   task automatic check_log(input string tag, input int k, input int exp[$]);
      chk({tag, "_len"}, 32'(pop_log[k].size()), 32'(exp.size()));
      for (int i = 0; i < exp.size() && i < pop_log[k].size(); i++)
         chk($sformatf("%s_ord%0d", tag, i), 32'(pop_log[k][i]), 32'(exp[i]));
   endtask

   initial begin
      int e[$];
      n_cmp  = 0;
      n_fail = 0;
      sched[0] = '{0, 1, 2, 0, 0, 0};
      slen[0]  = 3;
      dep[0]   = 4;
      sched[1] = '{0, 0, 0, 0, 1, 2};
      slen[1]  = 6;
      dep[1]   = 8;
      rst = 1'b1;
      clear_in();
      ordy[0] = 1'b0;
      ordy[1] = 1'b0;
      mcu_seen[0] = 0;
      mcu_seen[1] = 0;
      @(negedge clk);
      do_reset();

      // 4:4:4 order, one 3-word block per channel
      pop_log[0].delete();
      mcu_seen[0] = 0;
      ordy[0] = 1'b1;
      for (int w = 0; w < 3; w++) begin
         for (int c = 0; c < 3; c++) begin
            iv[0][c] = 1'b1;
            id[0][c] = CW'(c * 16 + w);
            ie[0][c] = (w == 2);
         end
         tick();
      end
      clear_in();
      repeat (12) tick();
      e = '{0, 0, 0, 1, 1, 1, 2, 2, 2};
      check_log("s1", 0, e);
      chk("s1_mcu_count", 32'(mcu_seen[0]), 32'd1);

      // ch2 arrives first and must wait for ch0 and ch1
      pop_log[0].delete();
      for (int w = 0; w < 2; w++) begin
         iv[0][2] = 1'b1;
         id[0][2] = CW'(16'h200 + w);
         ie[0][2] = (w == 1);
         tick();
      end
      clear_in();
      tick();
      chk("s2_ch2_held", 32'(ov[0]), 32'd0);
      for (int w = 0; w < 2; w++) begin
         for (int c = 0; c < 2; c++) begin
            iv[0][c] = 1'b1;
            id[0][c] = CW'(16'h100 * c + w);
            ie[0][c] = (w == 1);
         end
         tick();
      end
      clear_in();
      repeat (10) tick();
      e = '{0, 0, 1, 1, 2, 2};
      check_log("s2", 0, e);

      // depth-4 FIFO on ch1 with output stalled: 5th and 6th words are dropped
      pop_log[0].delete();
      ordy[0] = 1'b0;
      for (int w = 0; w < 6; w++) begin
         iv[0][1] = 1'b1;
         id[0][1] = CW'(16'h1A0 + w);
         ie[0][1] = (w == 3);
         tick();
         if (w == 3) chk("s3_ready_after4", 32'(ir[0][1]), 32'd0);
      end
      clear_in();
      chk("s3_overflow_ch1", 32'(of[0][1]), 32'd1);
      chk("s3_overflow_ch0", 32'(of[0][0]), 32'd0);
      iv[0][0] = 1'b1; ie[0][0] = 1'b1; id[0][0] = CW'(16'h0AA);
      iv[0][2] = 1'b1; ie[0][2] = 1'b1; id[0][2] = CW'(16'h2AA);
      tick();
      clear_in();
      ordy[0] = 1'b1;
      repeat (10) tick();
      e = '{0, 1, 1, 1, 1, 2};
      check_log("s3", 0, e);

      // 4:2:0: four 2-word luma blocks, then one block each of ch1 and ch2
      pop_log[1].delete();
      mcu_seen[1] = 0;
      ordy[1] = 1'b1;
      for (int w = 0; w < 8; w++) begin
         iv[1][0] = 1'b1;
         id[1][0] = CW'(16'h400 + w);
         ie[1][0] = w[0];
         iv[1][1] = (w == 0);
         ie[1][1] = 1'b1;
         id[1][1] = CW'(16'h411);
         iv[1][2] = (w == 0);
         ie[1][2] = 1'b1;
         id[1][2] = CW'(16'h422);
         tick();
      end
      clear_in();
      repeat (14) tick();
      e = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 2};
      check_log("s4", 1, e);
      chk("s4_mcu_count", 32'(mcu_seen[1]), 32'd1);

      // backpressure 1,0,1 across a 3-word ch0 block
      pop_log[0].delete();
      ordy[0] = 1'b0;
      for (int w = 0; w < 3; w++) begin
         iv[0][0] = 1'b1;
         id[0][0] = CW'(16'h5A0 + w);
         ie[0][0] = (w == 2);
         tick();
      end
      clear_in();
      ordy[0] = 1'b1; tick();
      ordy[0] = 1'b0; tick(); tick();
      ordy[0] = 1'b1; repeat (4) tick();
      e = '{0, 0, 0};
      check_log("s5", 0, e);

      // randomized traffic on both instances, with one reset in the middle
      for (int n = 0; n < 800; n++) begin
         for (int k = 0; k < 2; k++) begin
            ordy[k] = ($urandom_range(0, 3) != 0);
            for (int c = 0; c < 3; c++) begin
               iv[k][c] = ($urandom_range(0, 3) == 0);
               ie[k][c] = ($urandom_range(0, 2) == 0);
               id[k][c] = CW'($urandom);
            end
         end
         tick();
         if (n == 400) do_reset();
      end
      clear_in();
      do_reset();

      // reset mid-MCU with five words buffered; next block starts on ch0
      ordy[0] = 1'b0;
      for (int w = 0; w < 3; w++) begin
         iv[0][0] = 1'b1;
         id[0][0] = CW'(16'h700 + w);
         iv[0][1] = (w < 2);
         id[0][1] = CW'(16'h710 + w);
         tick();
      end
      clear_in();
      chk("s7_valid_before", 32'(ov[0]), 32'd1);
      do_reset();
      pop_log[0].delete();
      iv[0][1] = 1'b1; ie[0][1] = 1'b1; id[0][1] = CW'(16'h7B1);
      tick();
      clear_in();
      iv[0][0] = 1'b1; ie[0][0] = 1'b1; id[0][0] = CW'(16'h7B0);
      tick();
      clear_in();
      ordy[0] = 1'b1;
      repeat (6) tick();
      e = '{0, 1};
      check_log("s7", 0, e);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/jpeg_code_mux.md
JPEG_CODE_MUX -- requirements
Module: jpeg_code_mux

Interface
REQ-001 SHALL have parameter CODE_WIDTH, default 32: bit width of one entropy-coder code word.
REQ-002 SHALL have parameter CHANNELS, default 3: number of colour-channel code streams, range 1..8.
REQ-003 SHALL have parameter FIFO_DEPTH, default 16: words per channel FIFO, power of two, at least 2.
REQ-004 SHALL have parameter MODE, default 0: 0 selects 4:4:4 order (one block per channel per MCU); 1 selects 4:2:0 order (four channel-0 blocks, then one block from each remaining channel).
REQ-005 SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-006 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port in_valid, input, [CHANNELS]: per-channel word valid.
REQ-008 SHALL have port in_data, input, [CHANNELS][CODE_WIDTH]: per-channel code word.
REQ-009 SHALL have port in_eob, input, [CHANNELS]: marks the last word of an 8x8 block.
REQ-010 SHALL have port in_ready, output, [CHANNELS]: high when that channel's FIFO is not full.
REQ-011 SHALL have port out_valid, output, 1 bit: merged-stream word valid.
REQ-012 SHALL have port out_data, output, CODE_WIDTH: merged code word.
REQ-013 SHALL have port out_eob, output, 1 bit: end-of-block flag that travels with the word.
REQ-014 SHALL have port out_chan, output, clog2(CHANNELS) bits (minimum 1): source channel of the current word.
REQ-015 SHALL have port out_ready, input, 1 bit: downstream accept.
REQ-016 SHALL have port mcu_done, output, 1 bit: one-cycle pulse marking MCU completion.
REQ-017 SHALL have port overflow, output, [CHANNELS]: sticky per-channel drop flag.

Function
REQ-018 Each channel SHALL push {data, eob} into its FIFO on any rising edge where in_valid and in_ready are both high.
REQ-019 in_ready SHALL equal NOT full, where full is evaluated from the registered count; a full FIFO SHALL refuse a push even if a pop occurs in the same cycle.
REQ-020 in_valid high while in_ready is low SHALL drop the word and set overflow for that channel; overflow SHALL be cleared only by reset.
REQ-021 out_valid SHALL equal NOT empty of the FIFO of channel cur_chan; out_data, out_eob and out_chan SHALL present that FIFO's head.
REQ-022 A word pushed at edge N SHALL be visible at the output in the cycle after edge N; there SHALL be no same-cycle bypass.
REQ-023 A word SHALL be popped on any edge where out_valid and out_ready are both high; output fields SHALL hold stable while out_valid is high and out_ready is low.
REQ-024 Sequencer state SHALL consist of cur_chan and blk_cnt (2 bits), and SHALL advance only on a pop where out_eob is high.
REQ-025 In MODE 0, the sequencer SHALL set cur_chan to cur_chan+1, wrapping from CHANNELS-1 to 0.
REQ-026 In MODE 1, when cur_chan is 0 and blk_cnt is below 3, the sequencer SHALL increment blk_cnt and hold cur_chan; otherwise it SHALL clear blk_cnt and advance cur_chan with wrap.
REQ-027 mcu_done SHALL pulse in the cycle after the eob pop that wraps cur_chan to 0.
REQ-028 When CHANNELS is 1, cur_chan SHALL stay 0 and every eob pop SHALL produce mcu_done (MODE 1: every fourth eob pop).
REQ-029 Other channels' FIFOs SHALL continue to accept writes while the sequencer waits on an empty current channel.
REQ-030 Each FIFO SHALL keep an occupancy count of clog2(FIFO_DEPTH)+1 bits, with read and write pointers wrapping modulo FIFO_DEPTH.

Reset
REQ-031 Asserting rst SHALL immediately clear all pointers and counts, cur_chan, blk_cnt, mcu_done and overflow, leaving out_valid at 0 and in_ready all 1, and SHALL discard any partial MCU.
REQ-032 FIFO storage SHALL not require reset; out_data is don't-care while out_valid is 0.

Structure
REQ-033 The code-word struct, the MODE encodings and the clog2 helper SHALL live in the shared entropy-coder package.
REQ-034 One sub-module, code_fifo (a single-channel synchronous FIFO with count, full and empty), SHALL be instantiated CHANNELS times in a generate loop.
REQ-035 This block SHALL replace the per-channel out array at the output of the JPEG top level.

Verification
REQ-036 MODE 0, CHANNELS=3: one 3-word block on each channel with out_ready=1 SHALL produce output order ch0,ch0,ch0,ch1,ch1,ch1,ch2,ch2,ch2, with mcu_done 1 cycle after the ch2 eob pop.
REQ-037 MODE 1: four 2-word ch0 blocks plus one block each on ch1 and ch2 SHALL produce output order ch0 x8, then ch1, then ch2, with exactly one mcu_done.
REQ-038 FIFO_DEPTH=4, out_ready=0: six pushes on ch1 SHALL give in_ready[1]=0 after the 4th push, the 5th and 6th words dropped, and overflow[1]=1.
REQ-039 Backpressure: out_ready toggled 1,0,1 SHALL keep out_data stable during the stall, with no loss or duplication.
REQ-040 Words arriving on ch2 first while cur_chan is 0 SHALL be held until ch0 and ch1 blocks pass; ch2 out_valid SHALL not appear early.
REQ-041 Asserting rst mid-MCU with 5 words buffered SHALL bring out_valid to 0 in the same cycle, and the next block SHALL start on ch0.
